// File: rtl/logic_unit_if.sv
//==============================================================================
// Module      : logic_unit_if
// Description : Operand/result handshake bundle for logic_unit_pipe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface logic_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_sel;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic             parity;

    // Operand source / result consumer side
    modport master (
        output in_valid, a, b, op, acc_sel, acc_clr, out_ready,
        input  in_ready, out_valid, y, zero, ones, parity
    );

    // Logic unit side
    modport slave (
        input  in_valid, a, b, op, acc_sel, acc_clr, out_ready,
        output in_ready, out_valid, y, zero, ones, parity
    );
endinterface

`default_nettype wire

// File: rtl/logic_unit_pipe.sv
//==============================================================================
// Module      : logic_unit_pipe
// Description : Two-stage pipelined bitwise logic unit with valid/ready ports.
//               Optional accumulator enabled by defining LOGIC_UNIT_ACC_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module logic_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    logic_unit_if.slave bus
);

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_OR   = 3'd1;
    localparam logic [2:0] c_OP_NOT  = 3'd2;
    localparam logic [2:0] c_OP_XOR  = 3'd3;
    localparam logic [2:0] c_OP_NAND = 3'd4;
    localparam logic [2:0] c_OP_NOR  = 3'd5;
    localparam logic [2:0] c_OP_XNOR = 3'd6;
    localparam logic [2:0] c_OP_PASS = 3'd7;

    // Stage 1 registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;

    // Stage 2 registers
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_y;
    logic             r_s2_zero;
    logic             r_s2_ones;
    logic             r_s2_parity;

    logic             w_s2_load;
    logic             w_in_ready;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_result;

    assign w_s2_load  = r_s1_valid && (!r_s2_valid || bus.out_ready);
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_in_fire  = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= c_OP_AND;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= bus.a;
            r_s1_b     <= bus.b;
            r_s1_op    <= bus.op;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

`ifdef LOGIC_UNIT_ACC_EN
    logic             r_s1_acc_sel;
    logic [WIDTH-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_acc_sel <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_acc_sel <= bus.acc_sel;
        end
    end

    // Clear dominates the load; the loaded result still reaches y through S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (bus.acc_clr) begin
            r_acc <= '0;
        end else if (w_s2_load) begin
            r_acc <= w_result;
        end
    end

    assign w_opa = r_s1_acc_sel ? r_acc : r_s1_a;
`else
    logic w_unused_acc_ports;

    assign w_unused_acc_ports = bus.acc_sel ^ bus.acc_clr;
    assign w_opa              = r_s1_a;
`endif

    always_comb begin
        w_result = '0;
        case (r_s1_op)
            c_OP_AND:  w_result = w_opa & r_s1_b;
            c_OP_OR:   w_result = w_opa | r_s1_b;
            c_OP_NOT:  w_result = ~w_opa;
            c_OP_XOR:  w_result = w_opa ^ r_s1_b;
            c_OP_NAND: w_result = ~(w_opa & r_s1_b);
            c_OP_NOR:  w_result = ~(w_opa | r_s1_b);
            c_OP_XNOR: w_result = ~(w_opa ^ r_s1_b);
            c_OP_PASS: w_result = w_opa;
            default:   w_result = '0;
        endcase
    end

    // Flags derive from the value being loaded so they always match y.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_y      <= '0;
            r_s2_zero   <= 1'b1;
            r_s2_ones   <= 1'b0;
            r_s2_parity <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid  <= 1'b1;
            r_s2_y      <= w_result;
            r_s2_zero   <= ~|w_result;
            r_s2_ones   <= &w_result;
            r_s2_parity <= ^w_result;
        end else if (bus.out_ready) begin
            r_s2_valid  <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.y         = r_s2_y;
    assign bus.zero      = r_s2_zero;
    assign bus.ones      = r_s2_ones;
    assign bus.parity    = r_s2_parity;

endmodule

`default_nettype wire

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit. Takes two WIDTH-bit operands and a 3-bit opcode through a valid/ready input port, computes one of eight bitwise functions, and returns the registered result with status flags through a valid/ready output port. It sits between an operand source (register file or bench driver) and a result consumer. It supports full-throughput streaming with backpressure and an optional accumulate mode.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  unit can accept a beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  function select
- acc_sel  in  1  use accumulator in place of A (only with LOGIC_UNIT_ACC_EN)
- acc_clr  in  1  clear accumulator (only with LOGIC_UNIT_ACC_EN)
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- zero  out  1  y == 0
- ones  out  1  y == all ones
- parity  out  1  XOR-reduction of y

Reset is synchronous and active-high on one clock, clk.

## Operation
- Opcodes:
  - 0 AND
  - 1 OR
  - 2 NOT (~A, B ignored)
  - 3 XOR
  - 4 NAND
  - 5 NOR
  - 6 XNOR
  - 7 PASS (A)
- Stage 1 (S1): registers a, b, op and acc_sel on input handshake (in_valid && in_ready).
- Stage 2 (S2): computes the function from the S1 registers, then registers y, zero, ones and parity together with out_valid.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || s2_load
- Flags are computed from the result written into S2, never recomputed from a stale y.
- Holding: while out_valid && !out_ready, y, the flags and out_valid hold stable. S1 holds its beat.
- Ordering: results leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - y = 0
  - zero = 1
  - ones = 0
  - parity = 0
  - accumulator = 0
  - both stage-valid bits = 0
- Latency: an input accepted in cycle N appears with out_valid = 1 in cycle N+2 when out_ready stays high.
- Throughput: one beat per cycle under continuous out_ready.
- Backpressure: after out_ready drops, at most 2 further beats are accepted (S1 + S2 full), then in_ready = 0. in_ready depends combinationally on out_ready.
- Simultaneous events: S2 emptying while S1 refills in the same cycle is legal, and throughput is maintained.
- Reset mid-operation: all in-flight beats are discarded. Outputs return to reset values on the next edge.

## Configuration
- Macro: LOGIC_UNIT_ACC_EN.

Defined:
- A WIDTH-bit accumulator register is instantiated.
- On every s2_load, the accumulator takes the new result.
- If the S1 beat has acc_sel = 1, S2 uses the accumulator value in place of the registered A. This gives correct back-to-back chaining: each beat sees the result of the immediately preceding beat.
- acc_clr = 1 zeroes the accumulator at the next edge. If it coincides with s2_load, the clear wins for the accumulator, but the result is still delivered on y.
- acc_clr acts independently of handshakes.

Not defined:
- No accumulator exists.
- acc_sel and acc_clr are ignored; ports remain present.
- A is always the registered operand.

## Test plan
- Reset, WIDTH=8: assert rst for 2 cycles -> in_ready=1, out_valid=0, y=0x00, zero=1, ones=0, parity=0.
- Opcode sweep: a=0xC5, b=0x3A, op=0..7, out_ready=1 -> y must be, in order:
  - 0x00 (zero=1)
  - 0xFF (ones=1)
  - 0x3A
  - 0xFF
  - 0xFF
  - 0x00
  - 0x00
  - 0xC5 (parity=0)
  
  Each result arrives exactly 2 cycles after its input.
- Backpressure: stream 5 XOR beats with out_ready=0 -> exactly 2 accepted, in_ready=0 from cycle 3. Raise out_ready -> all 5 results emerge in order, none lost or duplicated, y stable while stalled.
- Random stall: 1000 random beats with random in_valid/out_ready -> output sequence matches a reference-model queue, and flags match y.
- Accumulate (LOGIC_UNIT_ACC_EN):
  - acc_clr, then OR b=0x01, OR b=0x02, OR b=0x80 back-to-back with acc_sel=1 -> y = 0x01, 0x03, 0x83.
  - Then acc_clr coincident with a load -> that y still delivered, and the next acc_sel PASS yields 0x00.
- Reset mid-stream: assert rst with S1 and S2 full -> out_valid=0 next cycle, accumulator=0, no stale result emitted after release.
